method_port_driver: RTL
=======================

# method_port_driver

Initiator-side driver for the two-operand method-port interface of the 6-bit design under test: start(Sta,Stb), value method result(Stc), action-value method check(Std). It takes one command from a valid/ready queue, calls start, samples result, calls check, and returns both values as one response. Every call honours the RDY/EN method protocol. It sits between the stimulus generator and the DUT in the port-renaming bench.

## Interface
Parameters:
- WIDTH, 6, operand/result width
- TIMEOUT, 15, maximum cycles spent waiting on any one RDY before aborting (1..255)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle
- cmd_a, cmd_b, cmd_c, cmd_d  in  WIDTH each  operands for Sta, Stb, Stc, Std
- start_Sta, start_Stb  out  WIDTH each  start arguments
- EN_start  out  1  start call
- RDY_start  in  1  start callable
- result_Stc  out  WIDTH  result argument
- result  in  WIDTH  result return value
- RDY_result  in  1  result valid
- check_Std  out  WIDTH  check argument
- EN_check  out  1  check call
- check  in  WIDTH  check return value
- RDY_check  in  1  check callable
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_result, rsp_check  out  WIDTH each  captured values
- rsp_timeout  out  1  transaction aborted by timeout
- txn_count  out  8  completed responses, wraps 255→0

## Operation
- States: IDLE, START, RESULT, CHECK, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch a/b/c/d, clear captures and the timeout flag, go to START.
- START: drive start_Sta/Stb from the latches. EN_start = RDY_start (combinational, START only). On an edge with RDY_start, go to RESULT.
- RESULT: drive result_Stc. On an edge with RDY_result, capture result into rsp_result and go to CHECK.
- CHECK: drive check_Std. EN_check = RDY_check. On that edge, capture check into rsp_check and go to RESP.
- RESP: rsp_valid=1 and the response fields are held stable. On rsp_ready, increment txn_count and go to IDLE.
- Argument outputs are 0 outside their own state. EN is never asserted while the matching RDY is low.
- Timeout: a wait counter clears on entry to START, RESULT and CHECK, and increments each cycle the awaited RDY is low.
  - When it reaches TIMEOUT with RDY still low, set rsp_timeout and go to RESP.
  - Captures not yet taken remain 0.
  - No EN is issued on the abort edge.
- Reset (synchronous RST): any state, mid-transaction included, goes to IDLE. All outputs and registers go to 0: cmd_ready=1 in IDLE, EN_* 0, rsp_* 0, txn_count 0. A transaction in flight is dropped without a response.

## Timing
- All RDY high: command accepted at edge 0, EN_start high in cycle 1, result captured edge 2, EN_check high in cycle 3, rsp_valid from cycle 4. Command-to-response latency is 4 cycles.
- Back-to-back throughput is one transaction per 5 cycles. cmd_ready=0 from START through RESP.
- Each cycle RDY is low adds one cycle.
- A timeout abort occurs TIMEOUT cycles after state entry.
- rsp_valid holds until rsp_ready. A response is consumed at the edge where rsp_valid&&rsp_ready. The next command cannot be accepted in that same edge.
- txn_count counts timed-out responses too. 255+1 wraps to 0.

## Structure
- Shared package method_drv_pkg:
  - state enum
  - response struct {result, check, timeout}
  - default TIMEOUT constant
- One sub-module, method_wait_timer: clear, count-enable and expired outputs; 8-bit counter compared against TIMEOUT. The FSM remains in the top.

## Test plan
- All RDY high, cmd a=1,b=2,c=3,d=4, DUT result=6'h15, check=6'h2A:
  - EN_start in cycle 1 with Sta=1,Stb=2.
  - Stc=3 in cycle 2.
  - EN_check with Std=4 in cycle 3.
  - rsp_valid in cycle 4 with result=21, check=42, timeout=0.
- RDY_start low for 3 cycles, then high: EN_start only in the first RDY-high cycle, response 3 cycles later than the baseline.
- RDY_result stuck low, TIMEOUT=15:
  - rsp_valid with rsp_timeout=1, rsp_result=0 and rsp_check=0.
  - EN_check never asserted.
- rsp_ready low for 5 cycles: response fields are stable, cmd_ready=0, and txn_count increments exactly once on release.
- RST asserted in CHECK: next cycle IDLE, all EN=0, rsp_valid=0, txn_count=0. A new command then completes normally.
- 256 back-to-back transactions: txn_count reads 0 and the 5-cycle spacing is held.

Source files
------------

// File: rtl/method_drv_pkg.sv
// ============================================================================
//  Module      : method_drv_pkg
//  Description : Shared types and constants for the method-port driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package method_drv_pkg;

    localparam int unsigned c_DEF_WIDTH   = 6;
    localparam int unsigned c_DEF_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_RESULT = 3'd2,
        ST_CHECK  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    typedef struct packed {
        logic [c_DEF_WIDTH-1:0] result;
        logic [c_DEF_WIDTH-1:0] check;
        logic                   timeout;
    } rsp_t;

    // States in which the driver is blocked on a callee RDY.
    function automatic logic is_wait_state(input state_e st);
        return (st == ST_START) || (st == ST_RESULT) || (st == ST_CHECK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/method_wait_timer.sv
// ============================================================================
//  Module      : method_wait_timer
//  Description : 8-bit RDY wait counter; flags the cycle whose miss aborts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module method_wait_timer
    import method_drv_pkg::*;
#(
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam logic [7:0] c_LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = 8'd0;
        end else if (i_count_en) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry fires on the miss that would bring the count up to TIMEOUT.
    assign o_expired = i_count_en && (count_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/method_port_driver.sv
// ============================================================================
//  Module      : method_port_driver
//  Description : Sequences start/result/check method calls per command.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module method_port_driver
    import method_drv_pkg::*;
#(
    parameter int WIDTH   = c_DEF_WIDTH,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIDTH-1:0] cmd_c,
    input  logic [WIDTH-1:0] cmd_d,
    output logic [WIDTH-1:0] start_Sta,
    output logic [WIDTH-1:0] start_Stb,
    output logic             EN_start,
    input  logic             RDY_start,
    output logic [WIDTH-1:0] result_Stc,
    input  logic [WIDTH-1:0] result,
    input  logic             RDY_result,
    output logic [WIDTH-1:0] check_Std,
    output logic             EN_check,
    input  logic [WIDTH-1:0] check,
    input  logic             RDY_check,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_check,
    output logic             rsp_timeout,
    output logic [7:0]       txn_count
);

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [WIDTH-1:0] c_q,       c_d;
    logic [WIDTH-1:0] d_q,       d_d;
    logic [WIDTH-1:0] res_q,     res_d;
    logic [WIDTH-1:0] chk_q,     chk_d;
    logic             tmo_q,     tmo_d;
    logic [7:0]       cnt_q,     cnt_d;

    logic w_awaited_rdy;
    logic w_count_en;
    logic w_clear;
    logic w_expired;

    always_comb begin
        w_awaited_rdy = 1'b0;
        case (state_q)
            ST_START:  w_awaited_rdy = RDY_start;
            ST_RESULT: w_awaited_rdy = RDY_result;
            ST_CHECK:  w_awaited_rdy = RDY_check;
            default:   w_awaited_rdy = 1'b0;
        endcase
        w_count_en = is_wait_state(state_q) && !w_awaited_rdy;
    end

    // Any state change restarts the wait budget for the next RDY.
    assign w_clear = (state_d != state_q);

    method_wait_timer #(
        .TIMEOUT    (TIMEOUT)
    ) u_wait_timer (
        .clk        (CLK),
        .rst        (RST),
        .i_clear    (w_clear),
        .i_count_en (w_count_en),
        .o_expired  (w_expired)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        res_d      = res_q;
        chk_d      = chk_q;
        tmo_d      = tmo_q;
        cnt_d      = cnt_q;
        cmd_ready  = 1'b0;
        start_Sta  = '0;
        start_Stb  = '0;
        EN_start   = 1'b0;
        result_Stc = '0;
        check_Std  = '0;
        EN_check   = 1'b0;
        rsp_valid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    c_d     = cmd_c;
                    d_d     = cmd_d;
                    res_d   = '0;
                    chk_d   = '0;
                    tmo_d   = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                start_Sta = a_q;
                start_Stb = b_q;
                EN_start  = RDY_start;
                if (RDY_start) begin
                    state_d = ST_RESULT;
                end else if (w_expired) begin
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESULT: begin
                result_Stc = c_q;
                if (RDY_result) begin
                    res_d   = result;
                    state_d = ST_CHECK;
                end else if (w_expired) begin
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_CHECK: begin
                check_Std = d_q;
                EN_check  = RDY_check;
                if (RDY_check) begin
                    chk_d   = check;
                    state_d = ST_RESP;
                end else if (w_expired) begin
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            res_q   <= '0;
            chk_q   <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            res_q   <= res_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_result  = res_q;
    assign rsp_check   = chk_q;
    assign rsp_timeout = tmo_q;
    assign txn_count   = cnt_q;

endmodule

`default_nettype wire
